// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus: instruction-memory read port, datapath issue/branch port and halt status.
// The master side is driven by fetch_ctrl; the slave side by memory and datapath.
interface fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        br_valid;
  logic        br_taken;
  logic        halted;

  modport master (
    output imem_req, imem_addr, instr, pc_out, instr_valid, halted,
    input  imem_ack, imem_rdata, instr_ready, br_valid, br_taken
  );

  modport slave (
    input  imem_req, imem_addr, instr, pc_out, instr_valid, halted,
    output imem_ack, imem_rdata, instr_ready, br_valid, br_taken
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: requests a word at pc, issues it to the datapath, then steps pc.
// Optional performance counters are enabled by defining FETCH_CTRL_PERF_EN.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0040_0020
) (
  input  logic         clk,
  input  logic         start_up,
  fetch_ctrl_if.master bus
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0]  perf_retired,
  output logic [31:0]  perf_wait
`endif
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OPC_W = 6;

  localparam logic [OPC_W-1:0] OP_HALT = 6'b111111;
  localparam logic [OPC_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OPC_W-1:0] OP_BNE  = 6'b000101;
  localparam logic [OPC_W-1:0] OP_BLEZ = 6'b000110;
  localparam logic [OPC_W-1:0] OP_BGTZ = 6'b000111;
  localparam logic [OPC_W-1:0] OP_J    = 6'b000010;
  localparam logic [OPC_W-1:0] OP_JAL  = 6'b000011;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ISSUE,
    WAIT_BR,
    HALT
  } state_e;

  state_e            state_q;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   instr_q;
  logic [XLEN-1:0]   pc_out_q;
  logic              imem_req_q;
  logic              instr_valid_q;
  logic              halted_q;

  logic [OPC_W-1:0]  opcode;
  logic [XLEN-1:0]   pc_plus4;
  logic [XLEN-1:0]   br_offset;
  logic [XLEN-1:0]   br_target;
  logic [XLEN-1:0]   jmp_target;

  // Next-pc candidates; pc is kept word aligned so all sums stay aligned and wrap mod 2^32.
  always_comb begin
    opcode     = instr_q[31:26];
    pc_plus4   = pc_q + XLEN'(4);
    br_offset  = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    br_target  = pc_plus4 + br_offset;
    jmp_target = {pc_plus4[31:28], instr_q[25:0], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (start_up) begin
      state_q       <= IDLE;
      pc_q          <= {RESET_PC[31:2], 2'b00};
      instr_q       <= '0;
      pc_out_q      <= '0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q    <= REQ;
          imem_req_q <= 1'b1;
        end
        REQ: begin
          if (bus.imem_ack) begin
            instr_q       <= bus.imem_rdata;
            pc_out_q      <= pc_q;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
            state_q       <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.instr_ready) begin
            instr_valid_q <= 1'b0;
            case (opcode)
              OP_HALT: begin
                state_q  <= HALT;
                halted_q <= 1'b1;
              end
              OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                state_q <= WAIT_BR;
              end
              OP_J, OP_JAL: begin
                pc_q       <= jmp_target;
                imem_req_q <= 1'b1;
                state_q    <= REQ;
              end
              default: begin
                pc_q       <= pc_plus4;
                imem_req_q <= 1'b1;
                state_q    <= REQ;
              end
            endcase
          end
        end
        WAIT_BR: begin
          if (bus.br_valid) begin
            pc_q       <= bus.br_taken ? br_target : pc_plus4;
            imem_req_q <= 1'b1;
            state_q    <= REQ;
          end
        end
        HALT: begin
          state_q <= HALT;
        end
        default: begin
          state_q       <= IDLE;
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.pc_out      = pc_out_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.halted      = halted_q;

`ifdef FETCH_CTRL_PERF_EN
  logic [XLEN-1:0] perf_retired_q;
  logic [XLEN-1:0] perf_wait_q;

  // Both counters stop naturally in HALT since neither condition can occur there.
  always_ff @(posedge clk) begin
    if (start_up) begin
      perf_retired_q <= '0;
      perf_wait_q    <= '0;
    end else begin
      if (state_q == ISSUE && bus.instr_ready) begin
        perf_retired_q <= perf_retired_q + XLEN'(1);
      end
      if ((state_q == REQ && !bus.imem_ack) || state_q == WAIT_BR) begin
        perf_wait_q <= perf_wait_q + XLEN'(1);
      end
    end
  end

  assign perf_retired = perf_retired_q;
  assign perf_wait    = perf_wait_q;
`endif

endmodule
